// File: rtl/fifo_ctrl_async_ram_if.sv
// Producer/consumer side of the show-ahead FIFO controller.
// The FIFO controller is the slave; the block feeding and draining it is the master.
interface fifo_ctrl_async_ram_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
);
   logic                  flush;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  full;
   logic                  almost_full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, wr_en, wr_data, rd_en,
      input  full, almost_full, rd_data, rd_valid, count, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en,
      output full, almost_full, rd_data, rd_valid, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_ctrl_async_ram.sv
// Show-ahead FIFO controller for an external dual-port RAM with a registered
// write port and an asynchronous read port. The head word is read straight off
// the RAM q output, so data is usable the cycle after it is written.
module fifo_ctrl_async_ram #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 6,
   parameter int AFULL_THRESH = 60
) (
   input  logic                  clk,
   input  logic                  rst,
   fifo_ctrl_async_ram_if.slave  bus,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic [ADDR_WIDTH-1:0] ram_wraddress,
   output logic                  ram_wren,
   output logic [ADDR_WIDTH-1:0] ram_rdaddress,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   localparam logic [ADDR_WIDTH:0] AFULL_LEVEL = (ADDR_WIDTH+1)'(AFULL_THRESH);

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic [ADDR_WIDTH:0] fill;
   logic                empty;
   logic                full;
   logic                wr_acc;
   logic                rd_acc;
   logic                overflow;
   logic                underflow;

   // Status flags and accept strobes decoded from the registered pointers.
   always_comb begin
      empty  = (wr_ptr == rd_ptr);
      full   = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
               (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
      fill   = wr_ptr - rd_ptr;
      wr_acc = bus.wr_en && !full && !bus.flush && !rst;
      rd_acc = bus.rd_en && !empty && !bus.flush && !rst;
   end

   // Pointer advance, flush/reset clearing and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (bus.wr_en && full) begin
            overflow <= 1'b1;
         end
         if (bus.rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

   assign ram_data      = bus.wr_data;
   assign ram_wraddress = wr_ptr[ADDR_WIDTH-1:0];
   assign ram_wren      = wr_acc;
   assign ram_rdaddress = rd_ptr[ADDR_WIDTH-1:0];

   assign bus.full        = full;
   assign bus.almost_full = (fill >= AFULL_LEVEL);
   assign bus.rd_data     = ram_q;
   assign bus.rd_valid    = !empty;
   assign bus.count       = fill;
   assign bus.overflow    = overflow;
   assign bus.underflow   = underflow;

endmodule
